// File: rtl/neu_grid_ctrl.sv
// Grid sequencer for the wavefront path-cost array.
// Streams node weights into the array and tracks which nodes are blocked.
// Seeds the array from a source node and runs relaxation until it settles
// or the iteration limit is hit.
module neu_grid_ctrl #(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int IDX_W    = 4,
   parameter int MAX_ITER = 1024,
   localparam int N       = ROWS * COLS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_start,
   input  logic             w_valid,
   input  logic [3:0]       w_data,
   output logic             w_ready,
   input  logic             solve_start,
   input  logic [IDX_W-1:0] src_idx,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic             err_src,
   output logic [15:0]      iter_count,
   output logic             grid_rst,
   output logic [N-1:0]     grid_clr,
   output logic [N-1:0]     grid_ld,
   output logic [3:0]       grid_ld_weight,
   input  logic [N-1:0]     grid_path_mod
);

   localparam int NP = 2 ** IDX_W;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_INIT, S_RELAX, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] src_q, src_d;
   logic [N-1:0]     mask_q, mask_d;
   logic [15:0]      iter_q, iter_d;
   logic             timeout_q, timeout_d;
   logic             err_q, err_d;
   logic [3:0]       wld_q, wld_d;

   // The mask is zero-extended to the full index range so an out-of-range
   // source can be tested without an out-of-bounds select.
   logic [NP-1:0] mask_ext;
   logic          src_bad;
   logic          active;

   assign mask_ext   = NP'(mask_q);
   assign src_bad    = (32'(src_idx) >= N) || mask_ext[src_idx];
   // Blocked nodes never update, so any flag they raise is noise.
   assign active     = |(grid_path_mod & ~mask_q);

   assign timeout    = timeout_q;
   assign err_src    = err_q;
   assign iter_count = iter_q;

   // Next-state and output decode.
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      src_d          = src_q;
      mask_d         = mask_q;
      iter_d         = iter_q;
      timeout_d      = timeout_q;
      err_d          = err_q;
      wld_d          = wld_q;
      w_ready        = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;
      grid_rst       = 1'b0;
      grid_clr       = '0;
      grid_ld        = '0;
      grid_ld_weight = wld_q;
      case (state_q)
         S_IDLE: begin
            if (load_start) begin
               // Load has priority; a simultaneous solve request is dropped.
               idx_d   = '0;
               state_d = S_LOAD;
            end else if (solve_start) begin
               timeout_d = 1'b0;
               iter_d    = '0;
               if (src_bad) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b0;
                  src_d   = src_idx;
                  state_d = S_INIT;
               end
            end
         end
         S_LOAD: begin
            w_ready = 1'b1;
            busy    = 1'b1;
            if (w_valid) begin
               grid_ld        = N'(1) << idx_q;
               grid_ld_weight = w_data;
               wld_d          = w_data;
               mask_d[idx_q]  = (w_data == 4'hF);
               idx_d          = idx_q + 1'b1;
               if (32'(idx_q) == N - 1) state_d = S_DONE;
            end
         end
         S_INIT: begin
            // Nodes give clr priority over rst, so the source seeds at cost 0.
            busy     = 1'b1;
            grid_rst = 1'b1;
            grid_clr = N'(1) << src_q;
            state_d  = S_RELAX;
         end
         S_RELAX: begin
            busy = 1'b1;
            if (active) begin
               iter_d = iter_q + 16'd1;
               if (iter_d == 16'(MAX_ITER)) begin
                  timeout_d = 1'b1;
                  state_d   = S_DONE;
               end
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         src_q     <= '0;
         mask_q    <= '0;
         iter_q    <= '0;
         timeout_q <= 1'b0;
         err_q     <= 1'b0;
         wld_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         src_q     <= src_d;
         mask_q    <= mask_d;
         iter_q    <= iter_d;
         timeout_q <= timeout_d;
         err_q     <= err_d;
         wld_q     <= wld_d;
      end
   end

endmodule

// File: tb/tb_neu_grid_ctrl.sv
// Table-driven bench for neu_grid_ctrl (4x4 grid, iteration limit of 8).
module tb_neu_grid_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start, w_valid, solve_start;
   logic [3:0]  w_data, src_idx;
   logic        w_ready, busy, done, timeout, err_src, grid_rst;
   logic [15:0] iter_count, grid_clr, grid_ld, grid_path_mod;
   logic [3:0]  grid_ld_weight;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   neu_grid_ctrl #(.ROWS(4), .COLS(4), .IDX_W(4), .MAX_ITER(8)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .w_valid(w_valid),
      .w_data(w_data), .w_ready(w_ready), .solve_start(solve_start),
      .src_idx(src_idx), .busy(busy), .done(done), .timeout(timeout),
      .err_src(err_src), .iter_count(iter_count), .grid_rst(grid_rst),
      .grid_clr(grid_clr), .grid_ld(grid_ld), .grid_ld_weight(grid_ld_weight),
      .grid_path_mod(grid_path_mod)
   );

   typedef struct {
      logic        ls, wv, ss;
      logic [3:0]  wd, si;
      logic [15:0] pm;
      logic [57:0] exp;
   } vec_t;

   vec_t vq[$];

   // Expected held values carried along while building the table.
   logic        bto, berr;
   logic [15:0] b_iter;
   logic [3:0]  bw;

   function automatic logic [3:0] wf(input int i);
      return 4'((i + 1) % 15);
   endfunction

   function automatic void add(input logic ls, input logic wv, input logic [3:0] wd,
                               input logic ss, input logic [3:0] si, input logic [15:0] pm,
                               input logic rdy, input logic bsy, input logic dn,
                               input logic [15:0] ld, input logic rs, input logic [15:0] clr);
      vec_t v;
      v.ls = ls; v.wv = wv; v.wd = wd; v.ss = ss; v.si = si; v.pm = pm;
      v.exp = {rdy, bsy, dn, bto, berr, b_iter, rs, clr, ld, bw};
      vq.push_back(v);
   endfunction

   function automatic logic [57:0] outs();
      return {w_ready, busy, done, timeout, err_src, iter_count,
              grid_rst, grid_clr, grid_ld, grid_ld_weight};
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   initial begin
      // ---------------- build the vector table ----------------
      bto = 0; berr = 0; b_iter = 0; bw = 0;
      // idle, stray weight beat ignored
      add(0,1,4'hF,0,0,0,               0,0,0,16'h0,0,16'h0);
      // load and solve together: load wins
      add(1,0,0,1,4'd2,0,               0,0,0,16'h0,0,16'h0);
      for (int i = 0; i < 16; i++) begin
         if (i == 2 || i == 6)
            add(0,0,4'hF,1,4'd1,0,      1,1,0,16'h0,0,16'h0);
         bw = wf(i);
         add(0,1,wf(i),0,0,0,           1,1,0,16'(1) << i,0,16'h0);
      end
      add(0,1,4'h7,0,0,0,               0,0,1,16'h0,0,16'h0);
      add(0,0,0,0,0,0,                  0,0,0,16'h0,0,16'h0);
      // solve from node 5, three active relax cycles
      add(0,0,0,1,4'd5,16'h0F0F,        0,0,0,16'h0,0,16'h0);
      add(0,0,0,0,0,16'h0F0F,           0,1,0,16'h0,1,16'h0020);
      for (int i = 0; i < 3; i++) begin
         add(0,0,0,0,0,16'h0F0F,        0,1,0,16'h0,0,16'h0);
         b_iter++;
      end
      add(0,0,0,0,0,16'h0,              0,1,0,16'h0,0,16'h0);
      add(0,0,0,0,0,16'h0,              0,0,1,16'h0,0,16'h0);
      add(0,0,0,0,0,16'h0,              0,0,0,16'h0,0,16'h0);
      // reload with node 9 blocked; status must hold through the load
      add(1,0,0,0,0,0,                  0,0,0,16'h0,0,16'h0);
      for (int i = 0; i < 16; i++) begin
         bw = (i == 9) ? 4'hF : 4'h1;
         add(0,1,bw,0,0,0,              1,1,0,16'(1) << i,0,16'h0);
      end
      add(0,0,0,0,0,0,                  0,0,1,16'h0,0,16'h0);
      add(0,0,0,0,0,0,                  0,0,0,16'h0,0,16'h0);
      // solve from 0 with only the blocked node flagging: settles at once
      add(0,0,0,1,4'd0,16'h0200,        0,0,0,16'h0,0,16'h0);
      b_iter = 0;
      add(0,0,0,0,0,16'h0200,           0,1,0,16'h0,1,16'h0001);
      add(0,0,0,0,0,16'h0200,           0,1,0,16'h0,0,16'h0);
      add(0,0,0,0,0,16'h0200,           0,0,1,16'h0,0,16'h0);
      add(0,0,0,0,0,16'h0200,           0,0,0,16'h0,0,16'h0);
      // solve from blocked node 9: rejected, done next cycle, no strobes
      add(0,0,0,1,4'd9,16'h0,           0,0,0,16'h0,0,16'h0);
      berr = 1;
      add(0,0,0,0,0,16'h0,              0,0,1,16'h0,0,16'h0);
      add(0,0,0,0,0,16'h0,              0,0,0,16'h0,0,16'h0);
      // stuck change flag on node 0: hits the limit after 8 relax cycles
      add(0,0,0,1,4'd0,16'h0001,        0,0,0,16'h0,0,16'h0);
      berr = 0;
      add(0,0,0,0,0,16'h0001,           0,1,0,16'h0,1,16'h0001);
      for (int i = 0; i < 8; i++) begin
         add(0,0,0,0,0,16'h0001,        0,1,0,16'h0,0,16'h0);
         b_iter++;
      end
      bto = 1;
      add(0,0,0,0,0,16'h0001,           0,0,1,16'h0,0,16'h0);
      add(0,0,0,0,0,16'h0001,           0,0,0,16'h0,0,16'h0);
      // quiet solve clears the timeout
      add(0,0,0,1,4'd3,16'h0,           0,0,0,16'h0,0,16'h0);
      bto = 0; b_iter = 0;
      add(0,0,0,0,0,16'h0,              0,1,0,16'h0,1,16'h0008);
      add(0,0,0,0,0,16'h0,              0,1,0,16'h0,0,16'h0);
      add(0,0,0,0,0,16'h0,              0,0,1,16'h0,0,16'h0);
      add(0,0,0,0,0,16'h0,              0,0,0,16'h0,0,16'h0);

      // ---------------- reset with random inputs ----------------
      rst = 1'b1;
      load_start = 0; w_valid = 0; w_data = 0; solve_start = 0; src_idx = 0;
      grid_path_mod = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         load_start    = 1'($urandom);
         w_valid       = 1'($urandom);
         w_data        = 4'($urandom);
         solve_start   = 1'($urandom);
         src_idx       = 4'($urandom);
         grid_path_mod = 16'($urandom);
         @(negedge clk);
         chk("reset_outputs", 64'(outs()), 64'h0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      load_start = 0; w_valid = 0; w_data = 0; solve_start = 0; src_idx = 0;
      grid_path_mod = 0;
      @(negedge clk);
      chk("post_reset_idle", 64'(outs()), 64'h0);

      // ---------------- apply table ----------------
      for (int k = 0; k < vq.size(); k++) begin
         @(posedge clk); #1;
         load_start    = vq[k].ls;
         w_valid       = vq[k].wv;
         w_data        = vq[k].wd;
         solve_start   = vq[k].ss;
         src_idx       = vq[k].si;
         grid_path_mod = vq[k].pm;
         @(negedge clk);
         chk($sformatf("vec%0d", k), 64'(outs()), 64'(vq[k].exp));
      end

      // ---------------- reset during relax ----------------
      @(posedge clk); #1;
      solve_start = 1; src_idx = 4'd0; grid_path_mod = 16'h0001;
      @(posedge clk); #1; solve_start = 0;          // INIT
      @(posedge clk); #1;                           // RELAX 1
      @(posedge clk); #1;                           // RELAX 2
      @(negedge clk);
      chk("relax_before_rst", 64'({busy, iter_count}), 64'({1'b1, 16'd1}));
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0; grid_path_mod = 16'h0;
      @(negedge clk);
      chk("abort_idle", 64'({busy, done, timeout, err_src, iter_count, grid_rst}), 64'h0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("abort_no_done", 64'({busy, done}), 64'h0);
      end
      // node 9 was blocked before the reset; it must now be accepted
      @(posedge clk); #1; solve_start = 1; src_idx = 4'd9;
      @(posedge clk); #1; solve_start = 0;
      @(negedge clk);
      chk("mask_cleared_init", 64'({err_src, grid_rst, grid_clr}), 64'({1'b0, 1'b1, 16'h0200}));
      begin
         logic seen;
         seen = 1'b0;
         for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done) seen = 1'b1;
         end
         chk("post_abort_solve_done", 64'(seen), 64'h1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
